// File: rtl/if_stage.sv
// Instruction-fetch stage: pairs the PC from pre-IF with its fetch response,
// buffers the word across ID stalls, and drops responses that belong to flushed fetches.
module if_stage #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pif_to_if_valid,
  input  logic [PC_W-1:0]   pif_pc,
  output logic              if_allowin,
  input  logic              inst_req_accepted,
  input  logic              inst_sram_data_ok,
  input  logic [INST_W-1:0] inst_sram_rdata,
  input  logic              flush,
  input  logic              id_allowin,
  output logic              if_to_id_valid,
  output logic [PC_W-1:0]   if_to_id_pc,
  output logic [INST_W-1:0] if_to_id_inst,
  output logic [CNT_W-1:0]  outstanding,
  output logic              discard_busy,
  output logic              resp_err
);

  logic              valid_reg;
  logic              inst_buf_valid_reg;
  logic              resp_err_reg;
  logic [CNT_W-1:0]  outstanding_reg;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  discard_cnt_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [INST_W-1:0] inst_buf_reg;

  logic live_ok;
  logic ready_go;
  logic load;
  logic own_cur;
  logic own_entering;
  logic orphan;
  logic hold;

  assign outstanding_next = outstanding_reg + CNT_W'(inst_req_accepted)
                          - CNT_W'(inst_sram_data_ok);

  assign live_ok  = inst_sram_data_ok & (discard_cnt_reg == '0);
  assign ready_go = valid_reg & (inst_buf_valid_reg | live_ok);

  assign if_allowin     = ~valid_reg | (ready_go & id_allowin) | flush;
  assign if_to_id_valid = valid_reg & ready_go & ~flush;
  assign if_to_id_pc    = pc_reg;
  // Bypass the response straight to ID so data_ok adds no latency.
  assign if_to_id_inst  = inst_buf_valid_reg ? inst_buf_reg : inst_sram_rdata;

  assign load         = if_allowin & ~flush;
  assign own_cur      = valid_reg & ~inst_buf_valid_reg;
  assign own_entering = ~own_cur & load & pif_to_if_valid;
  assign orphan       = live_ok & ~own_cur & ~own_entering & ~flush;
  assign hold         = own_cur & live_ok & ~id_allowin & ~flush;

  assign outstanding  = outstanding_reg;
  assign discard_busy = |discard_cnt_reg;
  assign resp_err     = resp_err_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_reg          <= 1'b0;
      inst_buf_valid_reg <= 1'b0;
      resp_err_reg       <= 1'b0;
      outstanding_reg    <= '0;
      discard_cnt_reg    <= '0;
      pc_reg             <= '0;
      inst_buf_reg       <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (orphan) begin
        resp_err_reg <= 1'b1;
      end
      if (flush) begin
        // Every request still in flight after this cycle belongs to killed fetches.
        valid_reg          <= 1'b0;
        inst_buf_valid_reg <= 1'b0;
        discard_cnt_reg    <= outstanding_next;
      end else begin
        if (inst_sram_data_ok && discard_cnt_reg != '0) begin
          discard_cnt_reg <= discard_cnt_reg - CNT_W'(1);
        end
        if (load) begin
          valid_reg          <= pif_to_if_valid;
          pc_reg             <= pif_pc;
          inst_buf_valid_reg <= own_entering & live_ok;
          if (own_entering && live_ok) begin
            inst_buf_reg <= inst_sram_rdata;
          end
        end else if (hold) begin
          inst_buf_reg       <= inst_sram_rdata;
          inst_buf_valid_reg <= 1'b1;
        end
      end
    end
  end

endmodule
